// File: rtl/prog_loader_if.sv
// Stream-in and program-memory bus between the boot loader and its neighbours.
// The slave modport is the loader's view; master is the environment side
// (byte source plus memory).
interface prog_loader_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int REG_WIDTH  = 8
);
  logic                  in_valid;
  logic [REG_WIDTH-1:0]  in_data;
  logic                  in_last;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [REG_WIDTH-1:0]  mem_din;
  logic [REG_WIDTH-1:0]  mem_dout;

  modport slave (
    input  in_valid, in_data, in_last, mem_dout,
    output in_ready, mem_we, mem_addr, mem_din
  );

  modport master (
    output in_valid, in_data, in_last, mem_dout,
    input  in_ready, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: streams bytes into memory from LOAD_BASE, keeps
// a running checksum, then reads the image back and compares the checksums
// before releasing the CPU core from reset.
module prog_loader #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    REG_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] LOAD_BASE  = 16'h0100,
  parameter int                    LOAD_DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  prog_loader_if.slave          bus,
  output logic                  core_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] byte_count
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE, S_ERROR} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(LOAD_DEPTH - 1);

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_byte_count;
  logic [REG_WIDTH-1:0]  r_checksum;
  logic [REG_WIDTH-1:0]  r_vsum;
  logic [ADDR_WIDTH-1:0] r_vidx;
  logic                  r_issue, r_issue_last;   // read address on bus this cycle
  logic                  r_rd_vld, r_rd_last;     // mem_dout valid this cycle
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [REG_WIDTH-1:0]  r_mem_din;

  logic                  w_in_ready, w_accept, w_depth_hit, w_final_rd, w_match;
  logic [REG_WIDTH-1:0]  w_sum_final;

  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_depth_hit = (r_byte_count == LAST_IDX);
  assign w_final_rd  = r_rd_vld & r_rd_last;
  assign w_sum_final = r_vsum + bus.mem_dout;
  assign w_match     = (w_sum_final == r_checksum);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_state_nxt  = r_state;
    w_in_ready   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    core_reset_n = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_LOAD;
      S_LOAD: begin
        w_in_ready = 1'b1;
        busy       = 1'b1;
        if (w_accept) begin
          if (bus.in_last)      w_state_nxt = S_VERIFY;
          else if (w_depth_hit) w_state_nxt = S_ERROR;
        end
      end
      S_VERIFY: begin
        busy = 1'b1;
        if (w_final_rd) w_state_nxt = w_match ? S_DONE : S_ERROR;
      end
      S_DONE: begin
        done         = 1'b1;
        core_reset_n = 1'b1;
        if (start) w_state_nxt = S_LOAD;
      end
      S_ERROR: begin
        error = 1'b1;
        if (start) w_state_nxt = S_LOAD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: write port, byte counter, checksums and read-back pipeline.
  // The final byte's write lands in the first VERIFY cycle; read addresses are
  // issued from the next cycle so every read sees fully written memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_count <= '0;
      r_checksum   <= '0;
      r_vsum       <= '0;
      r_vidx       <= '0;
      r_issue      <= 1'b0;
      r_issue_last <= 1'b0;
      r_rd_vld     <= 1'b0;
      r_rd_last    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
    end else begin
      r_mem_we  <= 1'b0;
      r_issue   <= 1'b0;
      r_rd_vld  <= r_issue;
      r_rd_last <= r_issue_last;
      case (r_state)
        S_LOAD: if (w_accept) begin
          r_mem_we     <= 1'b1;
          r_mem_addr   <= LOAD_BASE + r_byte_count;
          r_mem_din    <= bus.in_data;
          r_byte_count <= r_byte_count + 1'b1;
          r_checksum   <= r_checksum + bus.in_data;
        end
        S_VERIFY: begin
          if (r_vidx != r_byte_count) begin
            r_mem_addr   <= LOAD_BASE + r_vidx;
            r_issue      <= 1'b1;
            r_issue_last <= (r_vidx + 1'b1 == r_byte_count);
            r_vidx       <= r_vidx + 1'b1;
          end
          if (r_rd_vld) r_vsum <= w_sum_final;
        end
        default: if (start) begin
          r_byte_count <= '0;
          r_checksum   <= '0;
          r_vsum       <= '0;
          r_vidx       <= '0;
          r_issue_last <= 1'b0;
          r_rd_vld     <= 1'b0;
          r_rd_last    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.mem_we   = r_mem_we;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_din  = r_mem_din;
  assign byte_count   = r_byte_count;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a byte-wide memory model.
module tb_prog_loader;
  logic clk = 1'b0;
  logic reset, start;
  logic core_reset_n, busy, done, error;
  logic [15:0] byte_count;
  int checks = 0;
  int errors = 0;

  prog_loader_if #(.ADDR_WIDTH(16), .REG_WIDTH(8)) bus ();

  prog_loader dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .core_reset_n(core_reset_n), .busy(busy), .done(done), .error(error),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  // Memory model: synchronous write, one-cycle read latency, optional fault at 0101.
  logic [7:0] mem [0:65535];
  logic       corrupt = 1'b0;
  int         wr_cnt = 0;
  int         wr_0200 = 0;
  int         rd_hits [0:7];
  initial for (int i = 0; i < 8; i++) rd_hits[i] = 0;

  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_din;
      wr_cnt <= wr_cnt + 1;
      if (bus.mem_addr == 16'h0200) wr_0200 <= wr_0200 + 1;
    end
    bus.mem_dout <= (corrupt && bus.mem_addr == 16'h0101) ? 8'hFF : mem[bus.mem_addr];
    if (busy && !bus.in_ready && !bus.mem_we && bus.mem_addr[15:3] == 13'h0020)
      rd_hits[bus.mem_addr[2:0]] <= rd_hits[bus.mem_addr[2:0]] + 1;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = l;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL send_byte_timeout in_ready=%b required=1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done || error) && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (!(done || error)) begin
      errors++;
      $display("FAIL wait_end_timeout done=%b error=%b required=one_high", done, error);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h55; bus.in_last = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 16'h0 || bus.mem_din !== 8'h0) begin errors++; $display("FAIL rst_mem_bus addr=%h din=%h exp=0000/00", bus.mem_addr, bus.mem_din); end
    checks++; if ({core_reset_n, busy, done, error} !== 4'b0000) begin errors++; $display("FAIL rst_status got=%b exp=0000", {core_reset_n, busy, done, error}); end
    checks++; if (byte_count !== 16'h0) begin errors++; $display("FAIL rst_byte_count got=%h exp=0000", byte_count); end
    reset = 1'b0; start = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int wb = wr_cnt;
    int hb [0:3];
    for (int i = 0; i < 4; i++) hb[i] = rd_hits[i];
    pulse_start();
    checks++; if (busy !== 1'b1 || bus.in_ready !== 1'b1 || byte_count !== 16'h0) begin errors++; $display("FAIL basic_load_entry busy=%b ready=%b cnt=%h exp=1/1/0000", busy, bus.in_ready, byte_count); end
    send_byte(8'h03, 1'b0);
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h0100 || bus.mem_din !== 8'h03) begin errors++; $display("FAIL basic_first_write we=%b addr=%h din=%h exp=1/0100/03", bus.mem_we, bus.mem_addr, bus.mem_din); end
    send_byte(8'hA9, 1'b0);
    send_byte(8'h05, 1'b1);
    checks++; if (byte_count !== 16'd3 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic_count cnt=%0d ready=%b exp=3/0", byte_count, bus.in_ready); end
    wait_end();
    checks++; if (done !== 1'b1 || error !== 1'b0 || core_reset_n !== 1'b1) begin errors++; $display("FAIL basic_done done=%b err=%b crn=%b exp=1/0/1", done, error, core_reset_n); end
    checks++; if (mem[16'h0100] !== 8'h03 || mem[16'h0101] !== 8'hA9 || mem[16'h0102] !== 8'h05) begin errors++; $display("FAIL basic_mem got=%h %h %h exp=03 a9 05", mem[16'h0100], mem[16'h0101], mem[16'h0102]); end
    checks++; if (wr_cnt - wb !== 3) begin errors++; $display("FAIL basic_wr_cnt got=%0d exp=3", wr_cnt - wb); end
    checks++;
    if (rd_hits[0] == hb[0] || rd_hits[1] == hb[1] || rd_hits[2] == hb[2] || rd_hits[3] != hb[3]) begin
      errors++; $display("FAIL basic_verify_reads new_hits=%0d %0d %0d %0d exp=>0 >0 >0 0",
        rd_hits[0]-hb[0], rd_hits[1]-hb[1], rd_hits[2]-hb[2], rd_hits[3]-hb[3]);
    end
  endtask

  task automatic test_gapped();
    int wb = wr_cnt;
    pulse_start();
    send_byte(8'h10, 1'b0);
    bus.in_data = 8'hEE; bus.in_last = 1'b1;  // not valid: must be ignored
    @(negedge clk);
    checks++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0100 || byte_count !== 16'd1) begin errors++; $display("FAIL gap_idle we=%b addr=%h cnt=%0d exp=0/0100/1", bus.mem_we, bus.mem_addr, byte_count); end
    send_byte(8'h20, 1'b1);
    wait_end();
    checks++; if (done !== 1'b1 || byte_count !== 16'd2 || wr_cnt - wb !== 2) begin errors++; $display("FAIL gap_result done=%b cnt=%0d writes=%0d exp=1/2/2", done, byte_count, wr_cnt - wb); end
    checks++; if (mem[16'h0100] !== 8'h10 || mem[16'h0101] !== 8'h20) begin errors++; $display("FAIL gap_mem got=%h %h exp=10 20", mem[16'h0100], mem[16'h0101]); end
  endtask

  task automatic test_overflow();
    int wb = wr_cnt;
    int zb = wr_0200;
    logic [7:0] d;
    pulse_start();
    for (int i = 0; i < 256; i++) begin d = i[7:0]; send_byte(d, 1'b0); end
    checks++; if (error !== 1'b1 || bus.in_ready !== 1'b0 || core_reset_n !== 1'b0) begin errors++; $display("FAIL ovf_state err=%b ready=%b crn=%b exp=1/0/0", error, bus.in_ready, core_reset_n); end
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h01FF || bus.mem_din !== 8'hFF) begin errors++; $display("FAIL ovf_last_write we=%b addr=%h din=%h exp=1/01ff/ff", bus.mem_we, bus.mem_addr, bus.mem_din); end
    bus.in_valid = 1'b1; bus.in_data = 8'h77;
    repeat (5) @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (wr_0200 !== zb || wr_cnt - wb !== 256 || byte_count !== 16'd256) begin errors++; $display("FAIL ovf_257th w0200=%0d writes=%0d cnt=%0d exp=0/256/256", wr_0200 - zb, wr_cnt - wb, byte_count); end
  endtask

  task automatic test_corrupt();
    corrupt = 1'b1;
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b1);
    wait_end();
    checks++; if (error !== 1'b1 || done !== 1'b0 || core_reset_n !== 1'b0) begin errors++; $display("FAIL corrupt_result err=%b done=%b crn=%b exp=1/0/0", error, done, core_reset_n); end
    corrupt = 1'b0;
  endtask

  task automatic test_reset_abort();
    int wb = wr_cnt;
    pulse_start();
    send_byte(8'h41, 1'b0);
    send_byte(8'h42, 1'b0);
    reset = 1'b1; start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h43;
    @(negedge clk);
    reset = 1'b0; start = 1'b0; bus.in_valid = 1'b0;
    checks++; if (busy !== 1'b0 || bus.mem_we !== 1'b0 || byte_count !== 16'h0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL abort_idle busy=%b we=%b cnt=%0d ready=%b exp=0/0/0/0", busy, bus.mem_we, byte_count, bus.in_ready); end
    repeat (3) @(negedge clk);
    checks++; if (wr_cnt - wb !== 2) begin errors++; $display("FAIL abort_writes got=%0d exp=2", wr_cnt - wb); end
    pulse_start();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b1);
    wait_end();
    checks++; if (done !== 1'b1 || byte_count !== 16'd2 || mem[16'h0100] !== 8'hAA || mem[16'h0101] !== 8'hBB) begin errors++; $display("FAIL abort_reload done=%b cnt=%0d mem=%h %h exp=1/2/aa bb", done, byte_count, mem[16'h0100], mem[16'h0101]); end
  endtask

  task automatic test_start_rules();
    pulse_start();
    send_byte(8'h11, 1'b0);
    pulse_start();  // must be ignored mid-load
    checks++; if (byte_count !== 16'd1 || busy !== 1'b1 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL start_in_load cnt=%0d busy=%b ready=%b exp=1/1/1", byte_count, busy, bus.in_ready); end
    send_byte(8'h22, 1'b1);
    wait_end();
    checks++; if (done !== 1'b1 || byte_count !== 16'd2) begin errors++; $display("FAIL start_load_done done=%b cnt=%0d exp=1/2", done, byte_count); end
    pulse_start();
    checks++; if (core_reset_n !== 1'b0 || byte_count !== 16'h0 || done !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL start_in_done crn=%b cnt=%0d done=%b ready=%b exp=0/0/0/1", core_reset_n, byte_count, done, bus.in_ready); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_gapped();
    test_overflow();
    test_corrupt();
    test_reset_abort();
    test_start_rules();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
